// File: rtl/iomem_fabric.sv
// iomem_fabric: picosoc iomem bus controller fanning out to NSLOTS peripherals.
// Ports: CLK/RST, iomem_* CPU side, p_* slot side, err_irq/err_addr fault report.
module iomem_fabric #(
  parameter logic [7:0]  BASE_ADDR = 8'h03,
  parameter int          NSLOTS    = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NSLOTS-1:0]        p_sel,
  output logic [3:0]               p_wstrb,
  output logic [15:0]              p_addr,
  output logic [31:0]              p_wdata,
  input  logic [32*NSLOTS-1:0]     p_rdata,
  input  logic [NSLOTS-1:0]        p_ready,
  output logic                     err_irq,
  output logic [31:0]              err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [31:0]        addr_q;
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic [NSLOTS-1:0]  sel_q;
  logic [3:0]         wstrb_q;
  logic [15:0]        paddr_q;
  logic [31:0]        wdata_q;
  logic               irq_q;
  logic [31:0]        err_addr_q;

  logic               hit;
  logic [NSLOTS-1:0]  dec_sel;
  logic               slot_rdy;
  logic [31:0]        slot_rdata;

  always_comb begin
    hit = (iomem_addr[31:24] == BASE_ADDR) &&
          (int'(iomem_addr[18:16]) < NSLOTS);
    dec_sel = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      dec_sel[i] = (iomem_addr[18:16] == 3'(i));
    end
  end

  // sel_q is one-hot and held through ACCESS, so masking with it
  // samples only the selected slot's strobe and data.
  always_comb begin
    slot_rdy   = |(p_ready & sel_q);
    slot_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (sel_q[i]) begin
        slot_rdata = slot_rdata | p_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      sel_q      <= '0;
      wstrb_q    <= '0;
      paddr_q    <= '0;
      wdata_q    <= '0;
      irq_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          irq_q   <= 1'b0;
          if (iomem_valid) begin
            addr_q  <= iomem_addr;
            paddr_q <= iomem_addr[15:0];
            wstrb_q <= iomem_wstrb;
            wdata_q <= iomem_wdata;
            if (hit) begin
              sel_q   <= dec_sel;
              cnt_q   <= '0;
              state_q <= S_ACCESS;
            end else begin
              ready_q    <= 1'b1;
              rdata_q    <= ERR_DATA;
              irq_q      <= 1'b1;
              err_addr_q <= iomem_addr;
              state_q    <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          // completion beats timeout when both land together
          if (slot_rdy) begin
            sel_q   <= '0;
            ready_q <= 1'b1;
            rdata_q <= (wstrb_q == 4'd0) ? slot_rdata : 32'd0;
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            sel_q      <= '0;
            ready_q    <= 1'b1;
            rdata_q    <= ERR_DATA;
            irq_q      <= 1'b1;
            err_addr_q <= addr_q;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          rdata_q <= '0;
          irq_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign p_sel       = sel_q;
  assign p_wstrb     = wstrb_q;
  assign p_addr      = paddr_q;
  assign p_wdata     = wdata_q;
  assign err_irq     = irq_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_iomem_fabric.sv
// tb_iomem_fabric: directed bench for iomem_fabric with a cycle-timeline
// model built from the access latency rules.
module tb_iomem_fabric;

  localparam int NS = 4;
  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int N = 1024;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              iomem_valid = 1'b0;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb = '0;
  logic [31:0]       iomem_addr = '0;
  logic [31:0]       iomem_wdata = '0;
  logic [31:0]       iomem_rdata;
  logic [NS-1:0]     p_sel;
  logic [3:0]        p_wstrb;
  logic [15:0]       p_addr;
  logic [31:0]       p_wdata;
  logic [32*NS-1:0]  p_rdata = '0;
  logic [NS-1:0]     p_ready = '0;
  logic              err_irq;
  logic [31:0]       err_addr;

  iomem_fabric #(
    .BASE_ADDR(8'h03),
    .NSLOTS(NS),
    .TIMEOUT(TO),
    .ERR_DATA(ERR)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .p_sel(p_sel),
    .p_wstrb(p_wstrb),
    .p_addr(p_addr),
    .p_wdata(p_wdata),
    .p_rdata(p_rdata),
    .p_ready(p_ready),
    .err_irq(err_irq),
    .err_addr(err_addr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // expected per-cycle outputs, indexed by the edge that produced them
  logic          e_rdy[N];
  logic [31:0]   e_rd[N];
  logic [NS-1:0] e_sel[N];
  logic          e_irq[N];
  logic [31:0]   e_ea[N];
  logic [15:0]   e_pa[N];
  logic [31:0]   e_wd[N];
  logic [3:0]    e_ws[N];

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  bit          chk_on = 0;
  int          sel_cyc = 0;
  int          rdy_at = -1;
  logic [31:0] cap_rd = '0;

  initial forever begin
    @(posedge CLK);
    #1;
    if (chk_on && cyc < N) begin
      chk("iomem_ready", {31'd0, iomem_ready}, {31'd0, e_rdy[cyc]});
      chk("iomem_rdata", iomem_rdata, e_rd[cyc]);
      chk("p_sel", {28'd0, p_sel}, {28'd0, e_sel[cyc]});
      chk("err_irq", {31'd0, err_irq}, {31'd0, e_irq[cyc]});
      chk("err_addr", err_addr, e_ea[cyc]);
      if (e_sel[cyc] != '0) begin
        chk("p_addr", {16'd0, p_addr}, {16'd0, e_pa[cyc]});
        chk("p_wdata", p_wdata, e_wd[cyc]);
        chk("p_wstrb", {28'd0, p_wstrb}, {28'd0, e_ws[cyc]});
      end
      if (p_sel != '0) sel_cyc++;
      if (iomem_ready) begin
        cap_rd = iomem_rdata;
        rdy_at = cyc;
      end
    end
  end

  // d = ACCESS cycle (1-based) in which the slot strobes p_ready; 0 = never
  task automatic model_txn(input logic [31:0] a, input logic [3:0] ws,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int d, output int n0, output int acc);
    int  resp;
    bit  mapped;
    bit  err;
    n0 = cyc + 1;
    mapped = (a[31:24] == 8'h03) && (int'(a[18:16]) < NS);
    if (!mapped) begin
      acc = 0;
      err = 1;
    end else if (d >= 1 && d <= TO) begin
      acc = d;
      err = 0;
    end else begin
      acc = TO;
      err = 1;
    end
    for (int c = n0; c < n0 + acc; c++) begin
      e_sel[c] = NS'(1) << a[18:16];
      e_pa[c]  = a[15:0];
      e_wd[c]  = wd;
      e_ws[c]  = ws;
    end
    resp = n0 + acc;
    e_rdy[resp] = 1'b1;
    e_rd[resp]  = err ? ERR : ((ws != 4'd0) ? 32'd0 : rd);
    if (err) begin
      e_irq[resp] = 1'b1;
      for (int c = resp; c < N; c++) e_ea[c] = a;
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int d, input bit hold, input bit noise3,
                     output int lat);
    int n0;
    int acc;
    int slot;
    @(negedge CLK);
    sel_cyc = 0;
    rdy_at  = -1;
    model_txn(a, ws, wd, rd, d, n0, acc);
    slot = int'(a[18:16]);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = ws;
    iomem_wdata = wd;
    p_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    if (slot < NS) p_rdata[32*slot +: 32] = rd;
    @(negedge CLK);
    if (!hold) begin
      iomem_valid = 1'b0;
      iomem_addr  = 32'h0301_FFFC;
      iomem_wdata = 32'h0;
      iomem_wstrb = 4'hF;
    end
    for (int i = 1; i <= acc; i++) begin
      p_ready = noise3 ? 4'b1000 : 4'b0000;
      if (i == d) p_ready[slot] = 1'b1;
      @(negedge CLK);
    end
    p_ready = '0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    lat = rdy_at - n0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat;
  int n0;

  initial begin
    for (int c = 0; c < N; c++) begin
      e_rdy[c] = 0; e_rd[c] = 0; e_sel[c] = 0; e_irq[c] = 0;
      e_ea[c] = 0; e_pa[c] = 0; e_wd[c] = 0; e_ws[c] = 0;
    end
    #1 RST = 1'b1;
    #1;
    chk("rst ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst rdata", iomem_rdata, 32'd0);
    chk("rst p_sel", {28'd0, p_sel}, 32'd0);
    chk("rst p_addr", {16'd0, p_addr}, 32'd0);
    chk("rst err_addr", err_addr, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_on = 1;

    txn(32'h0301_0004, 4'h0, 32'h0, 32'h1234_5678, 1, 1, 0, lat);
    chk("read latency", lat, 1);
    chk("read rdata", cap_rd, 32'h1234_5678);
    chk("read sel cycles", sel_cyc, 1);

    txn(32'h0300_0010, 4'b0011, 32'hA5A5_0F0F, 32'h5555_AAAA, 4, 0, 0, lat);
    chk("write latency", lat, 4);
    chk("write rdata", cap_rd, 32'd0);
    chk("write sel cycles", sel_cyc, 4);
    chk("write p_wdata held", p_wdata, 32'hA5A5_0F0F);
    chk("write p_wstrb held", {28'd0, p_wstrb}, 32'd3);

    txn(32'h0400_0000, 4'h0, 32'h0, 32'h0, 1, 1, 0, lat);
    chk("dec1 latency", lat, 0);
    chk("dec1 rdata", cap_rd, 32'hDEAD_BEEF);
    chk("dec1 err_addr", err_addr, 32'h0400_0000);
    chk("dec1 sel cycles", sel_cyc, 0);

    txn(32'h0305_0000, 4'h0, 32'h0, 32'h0, 1, 0, 0, lat);
    chk("dec2 latency", lat, 0);
    chk("dec2 rdata", cap_rd, 32'hDEAD_BEEF);
    chk("dec2 err_addr", err_addr, 32'h0305_0000);

    txn(32'h0302_0000, 4'h0, 32'h0, 32'h0BAD_0000, 0, 0, 0, lat);
    chk("tmo latency", lat, 4);
    chk("tmo sel cycles", sel_cyc, 4);
    chk("tmo rdata", cap_rd, 32'hDEAD_BEEF);
    chk("tmo err_addr", err_addr, 32'h0302_0000);

    txn(32'h0302_0008, 4'h0, 32'h0, 32'hCAFE_0002, 4, 0, 0, lat);
    chk("late ready latency", lat, 4);
    chk("late ready rdata", cap_rd, 32'hCAFE_0002);
    chk("late ready err_addr kept", err_addr, 32'h0302_0000);

    txn(32'h0300_0020, 4'h0, 32'h0, 32'h0BAD_F00D, 3, 0, 1, lat);
    chk("noise latency", lat, 3);
    chk("noise rdata", cap_rd, 32'h0BAD_F00D);

    @(negedge CLK);
    n0 = cyc + 1;
    for (int c = n0; c < n0 + 2; c++) begin
      e_sel[c] = 4'b0100;
      e_pa[c]  = 16'h0000;
      e_wd[c]  = 32'h0;
      e_ws[c]  = 4'h0;
    end
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0302_0000;
    iomem_wstrb = 4'h0;
    iomem_wdata = 32'h0;
    @(negedge CLK);
    iomem_valid = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    for (int c = cyc + 1; c < N; c++) e_ea[c] = 32'h0;
    #1;
    chk("mid rst p_sel", {28'd0, p_sel}, 32'd0);
    chk("mid rst ready", {31'd0, iomem_ready}, 32'd0);
    chk("mid rst err_addr", err_addr, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    txn(32'h0301_0100, 4'h0, 32'h0, 32'h7777_0001, 2, 0, 0, lat);
    chk("post rst latency", lat, 2);
    chk("post rst rdata", cap_rd, 32'h7777_0001);

    @(negedge CLK);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
